// File: rtl/idecode_pipe_if.sv
// Decode-stage bus: ID-side handshake, decode results toward EX, and the
// write-back port into the register file.
interface idecode_pipe_if #(
  parameter int DATA_W = 32
);
  // ID side
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       Instruction;
  logic              id_RegDst;
  logic              id_Jal;
  logic              flush;
  // EX side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic [DATA_W-1:0] Sign_extend;
  logic [4:0]        out_write_reg;
  // WB side
  logic              RegWrite;
  logic              MemtoReg;
  logic              Jal;
  logic [4:0]        wb_write_reg;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] opcplus4;

  modport master (
    output in_valid, Instruction, id_RegDst, id_Jal, flush, out_ready,
           RegWrite, MemtoReg, Jal, wb_write_reg, read_data, ALU_result, opcplus4,
    input  in_ready, out_valid, read_data_1, read_data_2, Sign_extend, out_write_reg
  );

  modport slave (
    input  in_valid, Instruction, id_RegDst, id_Jal, flush, out_ready,
           RegWrite, MemtoReg, Jal, wb_write_reg, read_data, ALU_result, opcplus4,
    output in_ready, out_valid, read_data_1, read_data_2, Sign_extend, out_write_reg
  );
endinterface

// File: rtl/idecode_pipe.sv
// MIPS instruction-decode stage: 32-entry register file with write-back,
// same-cycle WB bypass, immediate extension, destination resolution and a
// single valid/ready output register toward EX.
module idecode_pipe #(
  parameter int DATA_W     = 32,
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input logic           clk,
  input logic           rst,
  idecode_pipe_if.slave bus
);

  logic [DATA_W-1:0] r_regs [32];
  logic              r_out_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_sext;
  logic [4:0]        r_wreg;

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_wb_data;
  logic [4:0]        w_wb_addr;
  logic              w_wb_en;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_zext;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_sext;
  logic [4:0]        w_wreg;

  // Field decode, write-back selection, handshake and next decode result
  always_comb begin
    w_op       = bus.Instruction[31:26];
    w_rs       = bus.Instruction[25:21];
    w_rt       = bus.Instruction[20:16];
    w_rd       = bus.Instruction[15:11];
    w_imm      = bus.Instruction[15:0];

    w_wb_data  = bus.Jal ? bus.opcplus4 : (bus.MemtoReg ? bus.read_data : bus.ALU_result);
    w_wb_addr  = bus.Jal ? 5'd31 : bus.wb_write_reg;
    w_wb_en    = bus.RegWrite && (w_wb_addr != 5'd0);

    w_in_ready = !r_out_valid || bus.out_ready;
    w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // Operands see the write landing at this same edge
    w_rd1 = '0;
    if (w_rs != 5'd0)
      w_rd1 = (w_wb_en && (w_wb_addr == w_rs)) ? w_wb_data : r_regs[w_rs];
    w_rd2 = '0;
    if (w_rt != 5'd0)
      w_rd2 = (w_wb_en && (w_wb_addr == w_rt)) ? w_wb_data : r_regs[w_rt];

    w_zext = ZEXT_LOGIC && ((w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E));
    w_sext = w_zext ? {{(DATA_W-16){1'b0}}, w_imm}
                    : {{(DATA_W-16){w_imm[15]}}, w_imm};

    w_wreg = bus.id_Jal ? 5'd31 : (bus.id_RegDst ? w_rd : w_rt);
  end

  // Register file: cleared by reset, entry 0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++)
        r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[w_wb_addr] <= w_wb_data;
    end
  end

  // Output register: flush beats accept, accept beats drain, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_sext      <= '0;
      r_wreg      <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rd1       <= w_rd1;
      r_rd2       <= w_rd2;
      r_sext      <= w_sext;
      r_wreg      <= w_wreg;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.read_data_1   = r_rd1;
  assign bus.read_data_2   = r_rd2;
  assign bus.Sign_extend   = r_sext;
  assign bus.out_write_reg = r_wreg;

endmodule
